axi_decerr_slave: RTL and testbench

- AXI3 default/error slave on an unused slot of the fabric, downstream of the interconnect address decoder.
- Fully completes every transaction it receives so a stray master access cannot hang the bus.
- Responds DECERR (2'b11) on both channels; reads return a fixed fill pattern.
- Independent read and write engines; one outstanding transaction per direction.

---
 rtl/axi_decerr_slave.sv | 241 ++++++++++++++++++++++++
 tb/tb_axi_decerr_slave.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_decerr_slave.sv
// rtl/axi_decerr_slave.sv - AXI3 default slave that completes every access with DECERR
//
// Purpose:
//   Sits on an unused fabric slot behind the interconnect address decoder.
//   Every transaction it receives is fully completed, so a stray master access
//   cannot hang the bus. Both response channels return DECERR. Reads return a
//   fixed fill pattern. The read and write engines are independent, and each
//   allows one outstanding transaction.
//
// Ports:
//   aclk, areset_n                 clock, asynchronous active-low reset
//   aw* (valid/ready/addr/burst/
//        size/len/id)              write address channel (addr/burst/size ignored)
//   w*  (valid/ready/data/strb/
//        last)                     write data channel (data/strb discarded)
//   b*  (valid/ready/id/resp)      write response channel, bid echoes awid
//   ar* (valid/ready/addr/burst/
//        size/len/id)              read address channel (addr/burst/size ignored)
//   r*  (valid/ready/id/data/
//        resp/last)                read data channel, rid echoes arid
//   wlast_err                      sticky: wlast position disagreed with awlen

module axi_decerr_slave #(
    parameter int          aw   = 12,
    parameter int          dw   = 32,
    parameter int          idw  = 16,
    parameter logic [31:0] FILL = 32'hDEADBEEF
) (
    input  logic              aclk,
    input  logic              areset_n,

    input  logic              awvalid,
    output logic              awready,
    input  logic [aw-1:0]     awaddr,
    input  logic [1:0]        awburst,
    input  logic [2:0]        awsize,
    input  logic [3:0]        awlen,
    input  logic [idw-1:0]    awid,

    input  logic              wvalid,
    output logic              wready,
    input  logic [dw-1:0]     wdata,
    input  logic [dw/8-1:0]   wstrb,
    input  logic              wlast,

    output logic              bvalid,
    input  logic              bready,
    output logic [idw-1:0]    bid,
    output logic [1:0]        bresp,

    input  logic              arvalid,
    output logic              arready,
    input  logic [aw-1:0]     araddr,
    input  logic [1:0]        arburst,
    input  logic [2:0]        arsize,
    input  logic [3:0]        arlen,
    input  logic [idw-1:0]    arid,

    output logic              rvalid,
    input  logic              rready,
    output logic [idw-1:0]    rid,
    output logic [dw-1:0]     rdata,
    output logic [1:0]        rresp,
    output logic              rlast,

    output logic              wlast_err
);

    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Replicate the 32-bit pattern up to at least dw bits, then truncate.
    localparam int                      FILL_REPS = (dw + 31) / 32;
    localparam logic [FILL_REPS*32-1:0] FILL_WIDE = {FILL_REPS{FILL}};

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    // ------------------------------------------------------------------
    // Write engine
    // ------------------------------------------------------------------
    w_state_e         w_state_q, w_state_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic [idw-1:0]   bid_q, bid_d;
    logic             wlast_err_q, wlast_err_d;
    logic             awready_q, wready_q, bvalid_q;
    logic             w_end;

    always_comb begin
        w_state_d   = w_state_q;
        wcnt_d      = wcnt_q;
        bid_d       = bid_q;
        wlast_err_d = wlast_err_q;
        w_end       = 1'b0;

        case (w_state_q)
            W_IDLE: begin
                if (awvalid && awready_q) begin
                    bid_d     = awid;
                    wcnt_d    = awlen;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid && wready_q) begin
                    // The burst closes on whichever comes first: the master's
                    // wlast or the beat count from awlen. A mismatch is only
                    // flagged; the burst still completes so the bus never stalls.
                    w_end = wlast || (wcnt_q == 4'd0);
                    if (wcnt_q != 4'd0) begin
                        wcnt_d = wcnt_q - 4'd1;
                    end
                    if (wlast != (wcnt_q == 4'd0)) begin
                        wlast_err_d = 1'b1;
                    end
                    if (w_end) begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (bvalid_q && bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: begin
                w_state_d = W_IDLE;
            end
        endcase
    end

    // Handshake outputs are registered copies of the next-state decode, so
    // they change on the same edge as the state and never come from logic.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            w_state_q   <= W_IDLE;
            wcnt_q      <= 4'd0;
            bid_q       <= '0;
            wlast_err_q <= 1'b0;
            awready_q   <= 1'b1;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
        end else begin
            w_state_q   <= w_state_d;
            wcnt_q      <= wcnt_d;
            bid_q       <= bid_d;
            wlast_err_q <= wlast_err_d;
            awready_q   <= (w_state_d == W_IDLE);
            wready_q    <= (w_state_d == W_DATA);
            bvalid_q    <= (w_state_d == W_RESP);
        end
    end

    // ------------------------------------------------------------------
    // Read engine
    // ------------------------------------------------------------------
    r_state_e         r_state_q, r_state_d;
    logic [3:0]       rcnt_q, rcnt_d;
    logic [idw-1:0]   rid_q, rid_d;
    logic             rlast_q, rlast_d;
    logic             arready_q, rvalid_q;

    always_comb begin
        r_state_d = r_state_q;
        rcnt_d    = rcnt_q;
        rid_d     = rid_q;
        rlast_d   = rlast_q;

        case (r_state_q)
            R_IDLE: begin
                if (arvalid && arready_q) begin
                    rid_d     = arid;
                    rcnt_d    = arlen;
                    rlast_d   = (arlen == 4'd0);
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid_q && rready) begin
                    if (rcnt_q == 4'd0) begin
                        rlast_d   = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        // rlast for the next beat is precomputed from the
                        // current count so it stays a plain register output.
                        rcnt_d  = rcnt_q - 4'd1;
                        rlast_d = (rcnt_q == 4'd1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_state_q <= R_IDLE;
            rcnt_q    <= 4'd0;
            rid_q     <= '0;
            rlast_q   <= 1'b0;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            rcnt_q    <= rcnt_d;
            rid_q     <= rid_d;
            rlast_q   <= rlast_d;
            arready_q <= (r_state_d == R_IDLE);
            rvalid_q  <= (r_state_d == R_DATA);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign awready   = awready_q;
    assign wready    = wready_q;
    assign bvalid    = bvalid_q;
    assign bid       = bid_q;
    assign bresp     = RESP_DECERR;
    assign wlast_err = wlast_err_q;

    assign arready   = arready_q;
    assign rvalid    = rvalid_q;
    assign rid       = rid_q;
    assign rlast     = rlast_q;
    assign rresp     = RESP_DECERR;
    assign rdata     = FILL_WIDE[dw-1:0];

    // Address attributes and write payload are accepted but have no effect.
    logic unused_inputs;
    assign unused_inputs = ^{awaddr, awburst, awsize, wdata, wstrb,
                             araddr, arburst, arsize};

endmodule

// File: tb/tb_axi_decerr_slave.sv
// tb/tb_axi_decerr_slave.sv - self-checking bench for axi_decerr_slave

module tb_axi_decerr_slave;

    logic        aclk;
    logic        areset_n;
    logic        awvalid, awready;
    logic [11:0] awaddr;
    logic [1:0]  awburst;
    logic [2:0]  awsize;
    logic [3:0]  awlen;
    logic [15:0] awid;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bvalid, bready;
    logic [15:0] bid;
    logic [1:0]  bresp;
    logic        arvalid, arready;
    logic [11:0] araddr;
    logic [1:0]  arburst;
    logic [2:0]  arsize;
    logic [3:0]  arlen;
    logic [15:0] arid;
    logic        rvalid, rready;
    logic [15:0] rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        wlast_err;

    axi_decerr_slave dut (
        .aclk      (aclk),
        .areset_n  (areset_n),
        .awvalid   (awvalid),
        .awready   (awready),
        .awaddr    (awaddr),
        .awburst   (awburst),
        .awsize    (awsize),
        .awlen     (awlen),
        .awid      (awid),
        .wvalid    (wvalid),
        .wready    (wready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wlast     (wlast),
        .bvalid    (bvalid),
        .bready    (bready),
        .bid       (bid),
        .bresp     (bresp),
        .arvalid   (arvalid),
        .arready   (arready),
        .araddr    (araddr),
        .arburst   (arburst),
        .arsize    (arsize),
        .arlen     (arlen),
        .arid      (arid),
        .rvalid    (rvalid),
        .rready    (rready),
        .rid       (rid),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .wlast_err (wlast_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] id;
        logic        last;
    } r_exp_t;

    logic [15:0] exp_b[$];
    r_exp_t      exp_r[$];
    int          r_beats = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; the monitor samples on
    // the falling edge, so both see a settled cycle.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    r_exp_t      r_e;
    logic [15:0] b_e;
    logic        r_hold, b_hold;
    logic [15:0] h_rid, h_bid;
    logic [31:0] h_rdata;
    logic        h_rlast;

    always @(negedge aclk) begin
        if (!areset_n) begin
            r_hold = 1'b0;
            b_hold = 1'b0;
        end else begin
            if (r_hold) begin
                check_eq("r_stall_valid", rvalid, 1'b1);
                check_eq("r_stall_rid", rid, h_rid);
                check_eq("r_stall_rdata", rdata, h_rdata);
                check_eq("r_stall_rlast", rlast, h_rlast);
            end
            if (b_hold) begin
                check_eq("b_stall_valid", bvalid, 1'b1);
                check_eq("b_stall_bid", bid, h_bid);
            end
            if (rvalid && rready) begin
                r_beats++;
                if (exp_r.size() == 0) begin
                    check_eq("r_unexpected_beat", 1, 0);
                end else begin
                    r_e = exp_r.pop_front();
                    check_eq("rid", rid, r_e.id);
                    check_eq("rlast", rlast, r_e.last);
                end
                check_eq("rdata", rdata, 32'hDEADBEEF);
                check_eq("rresp", rresp, 2'b11);
            end
            if (bvalid && bready) begin
                if (exp_b.size() == 0) begin
                    check_eq("b_unexpected", 1, 0);
                end else begin
                    b_e = exp_b.pop_front();
                    check_eq("bid", bid, b_e);
                end
                check_eq("bresp", bresp, 2'b11);
            end
            r_hold  = rvalid && !rready;
            h_rid   = rid;
            h_rdata = rdata;
            h_rlast = rlast;
            b_hold  = bvalid && !bready;
            h_bid   = bid;
        end
    end

    // ------------------------------------------------------------------
    // Drivers
    // ------------------------------------------------------------------
    task automatic send_aw(input logic [15:0] id, input logic [3:0] len);
        int n = 0;
        exp_b.push_back(id);
        awvalid = 1'b1;
        awid    = id;
        awlen   = len;
        while (!awready && n < 100) begin tick(); n++; end
        if (n >= 100) check_eq("aw_timeout", n, 0);
        tick();
        awvalid = 1'b0;
    endtask

    task automatic send_w(input int nbeats, input int last_idx);
        for (int i = 0; i < nbeats; i++) begin
            int n = 0;
            wvalid = 1'b1;
            wlast  = (i == last_idx);
            wdata  = $urandom;
            while (!wready && n < 100) begin tick(); n++; end
            if (n >= 100) check_eq("w_timeout", n, 0);
            tick();
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
    endtask

    task automatic send_ar(input logic [15:0] id, input logic [3:0] len);
        int n = 0;
        for (int i = 0; i <= int'(len); i++) begin
            exp_r.push_back('{id: id, last: (i == int'(len))});
        end
        arvalid = 1'b1;
        arid    = id;
        arlen   = len;
        while (!arready && n < 100) begin tick(); n++; end
        if (n >= 100) check_eq("ar_timeout", n, 0);
        tick();
        arvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 200) begin tick(); n++; end
        if (n >= 200) check_eq("drain_timeout", n, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        bit [5:0] pat;

        areset_n = 1'b0;
        awvalid = 1'b0; awaddr = '0; awburst = 2'b01; awsize = 3'd2; awlen = '0; awid = '0;
        wvalid  = 1'b0; wdata  = '0; wstrb   = 4'hF;  wlast  = 1'b0;
        bready  = 1'b1;
        arvalid = 1'b0; araddr = '0; arburst = 2'b01; arsize = 3'd2; arlen = '0; arid = '0;
        rready  = 1'b1;

        repeat (3) @(posedge aclk);
        #1;
        check_eq("rst_awready", awready, 1'b1);
        check_eq("rst_arready", arready, 1'b1);
        check_eq("rst_wready", wready, 1'b0);
        check_eq("rst_bvalid", bvalid, 1'b0);
        check_eq("rst_rvalid", rvalid, 1'b0);
        check_eq("rst_rlast", rlast, 1'b0);
        check_eq("rst_bid", bid, 16'h0);
        check_eq("rst_rid", rid, 16'h0);
        check_eq("rst_wlast_err", wlast_err, 1'b0);
        areset_n = 1'b1;
        tick();

        // Single-beat write with W presented alongside AW: B two cycles later.
        exp_b.push_back(16'h00A5);
        awvalid = 1'b1; awid = 16'h00A5; awlen = 4'd0;
        wvalid  = 1'b1; wlast = 1'b1;
        tick();
        awvalid = 1'b0;
        check_eq("t1_awready_low", awready, 1'b0);
        check_eq("t1_wready", wready, 1'b1);
        check_eq("t1_bvalid_early", bvalid, 1'b0);
        tick();
        wvalid = 1'b0; wlast = 1'b0;
        check_eq("t1_bvalid", bvalid, 1'b1);
        check_eq("t1_bid", bid, 16'h00A5);
        check_eq("t1_bresp", bresp, 2'b11);
        tick();
        check_eq("t1_bvalid_done", bvalid, 1'b0);
        check_eq("t1_awready_back", awready, 1'b1);

        // Read burst with rready pattern 1,0,1,1,0,1 (bit 0 first).
        send_ar(16'h0123, 4'd3);
        check_eq("t2_arready_low", arready, 1'b0);
        check_eq("t2_rvalid", rvalid, 1'b1);
        pat = 6'b101101;
        for (int i = 0; i < 6; i++) begin
            rready = pat[i];
            tick();
        end
        rready = 1'b1;
        check_eq("t2_arready_back", arready, 1'b1);
        check_eq("t2_rvalid_done", rvalid, 1'b0);
        check_eq("t2_beats_left", exp_r.size(), 0);

        // B backpressure on an 8-beat write.
        bready = 1'b0;
        send_aw(16'h0B0B, 4'd7);
        send_w(8, 7);
        for (int i = 0; i < 10; i++) begin
            check_eq("t3_bvalid_held", bvalid, 1'b1);
            check_eq("t3_awready_low", awready, 1'b0);
            check_eq("t3_bid_held", bid, 16'h0B0B);
            tick();
        end
        bready = 1'b1;
        tick();
        check_eq("t3_bvalid_done", bvalid, 1'b0);
        check_eq("t3_awready_back", awready, 1'b1);
        check_eq("t3_wlast_err_clean", wlast_err, 1'b0);

        // Early wlast: awlen=3 but wlast on beat 2.
        send_aw(16'h0E0E, 4'd3);
        send_w(2, 1);
        check_eq("t4_wready_off", wready, 1'b0);
        check_eq("t4_bvalid", bvalid, 1'b1);
        check_eq("t4_wlast_err", wlast_err, 1'b1);
        wait_idle();

        // Simultaneous AW and AR.
        exp_b.push_back(16'h0001);
        exp_r.push_back('{id: 16'h0002, last: 1'b0});
        exp_r.push_back('{id: 16'h0002, last: 1'b1});
        awvalid = 1'b1; awid = 16'h0001; awlen = 4'd1;
        arvalid = 1'b1; arid = 16'h0002; arlen = 4'd1;
        tick();
        awvalid = 1'b0; arvalid = 1'b0;
        check_eq("t5_aw_taken", awready, 1'b0);
        check_eq("t5_ar_taken", arready, 1'b0);
        check_eq("t5_rvalid", rvalid, 1'b1);
        send_w(2, 1);
        wait_idle();
        check_eq("t5_wlast_err_sticky", wlast_err, 1'b1);
        check_eq("t5_awready_idle", awready, 1'b1);
        check_eq("t5_arready_idle", arready, 1'b1);

        // Reset in the middle of a 16-beat read.
        begin
            int n = 0;
            r_beats = 0;
            send_ar(16'h0FFF, 4'd15);
            while (r_beats < 5 && n < 100) begin tick(); n++; end
            if (n >= 100) check_eq("t6_beat_timeout", n, 0);
            check_eq("t6_beats_before_reset", r_beats, 5);
        end
        #1;
        areset_n = 1'b0;
        #1;
        check_eq("t6_rvalid_async", rvalid, 1'b0);
        check_eq("t6_arready_async", arready, 1'b1);
        exp_r.delete();
        exp_b.delete();
        tick();
        tick();
        areset_n = 1'b1;
        r_beats = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("t6_rvalid_idle", rvalid, 1'b0);
            check_eq("t6_arready_idle", arready, 1'b1);
        end
        check_eq("t6_no_stale_beats", r_beats, 0);
        check_eq("t6_rid_cleared", rid, 16'h0);
        check_eq("t6_wlast_err_cleared", wlast_err, 1'b0);

        check_eq("end_b_queue", exp_b.size(), 0);
        check_eq("end_r_queue", exp_r.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
